// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the radix-2 Viterbi ACS array.
// All helpers are constant functions so they can size and wire generate blocks.
package viterbi_pkg;

   localparam int              K_DEF    = 3;
   localparam logic [2:0]      G0_DEF   = 3'b111;
   localparam logic [2:0]      G1_DEF   = 3'b101;
   localparam int              BM_W_DEF = 2;
   localparam int              PM_W_DEF = 8;

   // Number of trellis states for constraint length k.
   function automatic int ns_of(input int k);
      return 1 << (k - 1);
   endfunction

   // Initial metric for every state except 0 at frame start.
   function automatic int bias_of(input int pm_w);
      return 1 << (pm_w - 2);
   endfunction

   // Modulo normalisation is only safe when the quarter range exceeds the worst metric spread.
   function automatic bit pm_w_ok(input int k, input int bm_w, input int pm_w);
      return (1 << (pm_w - 2)) > (2 * (k - 1) * ((1 << bm_w) - 1) + 1);
   endfunction

   // Predecessor j (0 or 1) of next state ns: j becomes the MSB, ns shifts down.
   function automatic int predecessor(input int ns, input int j, input int k);
      return (j << (k - 2)) | (ns >> 1);
   endfunction

   // Codeword index {c0,c1} emitted on the transition p -> ns with input bit u.
   function automatic int codeword(input int p, input int u, input int g0, input int g1);
      int r;
      r = (p << 1) | u;
      return ((^(r & g0)) ? 2 : 0) + ((^(r & g1)) ? 1 : 0);
   endfunction

endpackage

// File: rtl/viterbi_acs_array_if.sv
// Symbol-in / decision-out bundle between the branch-metric unit, the ACS array
// and the traceback unit.
interface viterbi_acs_if
   import viterbi_pkg::*;
#(
   parameter int K    = K_DEF,
   parameter int BM_W = BM_W_DEF,
   parameter int PM_W = PM_W_DEF
);

   logic                    en_a;
   logic                    i_start;
   logic [4*BM_W-1:0]       i_bm;

   logic [(1<<(K-1))-1:0]   o_dec;
   logic                    o_valid;
   logic [K-2:0]            o_best_st;
   logic [PM_W-1:0]         o_best_pm;
   logic                    o_norm;
   logic                    o_warm;

   modport master (
      output en_a, i_start, i_bm,
      input  o_dec, o_valid, o_best_st, o_best_pm, o_norm, o_warm
   );

   modport slave (
      input  en_a, i_start, i_bm,
      output o_dec, o_valid, o_best_st, o_best_pm, o_norm, o_warm
   );

endinterface

// File: rtl/viterbi_acs_array_acs_cell.sv
// One add-compare-select butterfly half: two candidate sums, survivor choice,
// decision bit and optional modulo normalisation of the survivor.
module acs_cell #(
   parameter int BM_W = 2,
   parameter int PM_W = 8
) (
   input  logic [PM_W-1:0] pm_p0,
   input  logic [PM_W-1:0] pm_p1,
   input  logic [BM_W-1:0] bm_p0,
   input  logic [BM_W-1:0] bm_p1,
   input  logic            norm,
   output logic [PM_W-1:0] pm_new,
   output logic            dec
);

   localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

   logic [PM_W-1:0] cand0;
   logic [PM_W-1:0] cand1;
   logic [PM_W-1:0] surv;

   assign cand0 = pm_p0 + PM_W'(bm_p0);
   assign cand1 = pm_p1 + PM_W'(bm_p1);

   // Strict compare: equal candidates keep predecessor p0.
   assign dec    = cand1 < cand0;
   assign surv   = dec ? cand1 : cand0;
   assign pm_new = norm ? surv - HALF : surv;

endmodule

// File: rtl/viterbi_acs_array.sv
// Radix-2 ACS array over all 2^(K-1) states: path-metric registers, frame-start
// injection, modulo normalisation, best-state search and warm-up counter.
module viterbi_acs_array
   import viterbi_pkg::*;
#(
   parameter int             K    = K_DEF,
   parameter logic [K-1:0]   G0   = G0_DEF,
   parameter logic [K-1:0]   G1   = G1_DEF,
   parameter int             BM_W = BM_W_DEF,
   parameter int             PM_W = PM_W_DEF
) (
   input logic          clk,
   input logic          rst,
   viterbi_acs_if.slave bus
);

   localparam int              NS      = ns_of(K);
   localparam int              SW      = K - 1;
   localparam int              CW      = $clog2(K);
   localparam logic [PM_W-1:0] BIAS    = PM_W'(bias_of(PM_W));
   localparam logic [CW-1:0]   CNT_MAX = CW'(K - 1);

   if (!pm_w_ok(K, BM_W, PM_W)) begin : g_bad_width
      $error("viterbi_acs_array: PM_W too narrow for K and BM_W");
   end

   logic [PM_W-1:0] pm_q [NS];
   logic [CW-1:0]   cnt_q;
   logic            valid_q;
   logic            norm_q;
   logic            warm_q;
   logic [NS-1:0]   dec_q;
   logic [SW-1:0]   best_st_q;
   logic [PM_W-1:0] best_pm_q;

   logic            start_step;
   logic [PM_W-1:0] src  [NS];
   logic [PM_W-1:0] pm_d [NS];
   logic [NS-1:0]   dec_d;
   logic            norm_d;
   logic [SW-1:0]   best_st_d;
   logic [PM_W-1:0] best_pm_d;
   logic [CW-1:0]   cnt_d;

   assign start_step = bus.en_a & bus.i_start;

   // A frame start replaces the stored metrics for this step only.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      for (int s = 0; s < NS; s++) begin
         src[s] = pm_q[s];
         if (start_step) src[s] = (s == 0) ? '0 : BIAS;
      end
   end

   always_comb begin
      norm_d = 1'b1;
      for (int s = 0; s < NS; s++) norm_d = norm_d & src[s][PM_W-1];
   end

   for (genvar g = 0; g < NS; g++) begin : g_cell
      localparam int P0 = predecessor(g, 0, K);
      localparam int P1 = predecessor(g, 1, K);
      localparam int U  = g % 2;
      localparam int N0 = codeword(P0, U, int'(G0), int'(G1));
      localparam int N1 = codeword(P1, U, int'(G0), int'(G1));

      acs_cell #(
         .BM_W (BM_W),
         .PM_W (PM_W)
      ) u_cell (
         .pm_p0  (src[P0]),
         .pm_p1  (src[P1]),
         .bm_p0  (bus.i_bm[N0*BM_W +: BM_W]),
         .bm_p1  (bus.i_bm[N1*BM_W +: BM_W]),
         .norm   (norm_d),
         .pm_new (pm_d[g]),
         .dec    (dec_d[g])
      );
   end

   // Only a strictly smaller metric displaces the current best, so ties resolve to the lower index.
   always_comb begin
      best_st_d = '0;
      best_pm_d = pm_d[0];
      for (int s = 1; s < NS; s++) begin
         if (pm_d[s] < best_pm_d) begin
            best_pm_d = pm_d[s];
            best_st_d = SW'(s);
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start_step)            cnt_d = CW'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
   end

   // NOTE: the metric array is reset like any register because reset defines the trellis start state.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : BIAS;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         norm_q    <= 1'b0;
         warm_q    <= 1'b0;
         dec_q     <= '0;
         best_st_q <= '0;
         best_pm_q <= '0;
      end else begin
         valid_q <= bus.en_a;
         if (bus.en_a) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
            cnt_q     <= cnt_d;
            norm_q    <= norm_d;
            warm_q    <= (cnt_d == CNT_MAX);
            dec_q     <= dec_d;
            best_st_q <= best_st_d;
            best_pm_q <= best_pm_d;
         end
      end
   end

   assign bus.o_valid   = valid_q;
   assign bus.o_dec     = dec_q;
   assign bus.o_best_st = best_st_q;
   assign bus.o_best_pm = best_pm_q;
   assign bus.o_norm    = norm_q;
   assign bus.o_warm    = warm_q;

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Directed bench for viterbi_acs_array (K=3, G=7/5, BM_W=2, PM_W=8) with an
// arithmetic trellis model checked every cycle plus hand-computed pins.
module tb_viterbi_acs_array;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   viterbi_acs_if #(.K(3), .BM_W(2), .PM_W(8)) bus ();

   viterbi_acs_array #(
      .K(3), .G0(3'b111), .G1(3'b101), .BM_W(2), .PM_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: four path metrics in plain integers plus expected outputs.
   int m_pm [4];
   int m_cnt;
   int exp_valid, exp_dec, exp_st, exp_pm, exp_norm, exp_warm;

   function automatic int par3(input int v);
      return ((v >> 2) ^ (v >> 1) ^ v) & 1;
   endfunction

   task automatic model_reset();
      m_pm[0] = 0; m_pm[1] = 64; m_pm[2] = 64; m_pm[3] = 64;
      m_cnt = 0;
      exp_valid = 0; exp_dec = 0; exp_st = 0; exp_pm = 0; exp_norm = 0; exp_warm = 0;
   endtask

   task automatic model_step(input int en, input int start, input int b0, input int b1,
                             input int b2, input int b3);
      int bm [4];
      int src [4];
      int nxt [4];
      int all_hi, dec, best;
      exp_valid = en;
      if (en == 0) return;
      bm[0] = b0; bm[1] = b1; bm[2] = b2; bm[3] = b3;
      for (int s = 0; s < 4; s++) src[s] = (start != 0) ? ((s == 0) ? 0 : 64) : m_pm[s];
      all_hi = 1;
      for (int s = 0; s < 4; s++) if (src[s] < 128) all_hi = 0;
      dec = 0;
      for (int ns = 0; ns < 4; ns++) begin
         int cand [2];
         for (int j = 0; j < 2; j++) begin
            int p, r;
            p = j * 2 + ns / 2;
            r = p * 2 + ns % 2;
            cand[j] = src[p] + bm[par3(r & 7) * 2 + par3(r & 5)];
         end
         if (cand[1] < cand[0]) begin
            nxt[ns] = cand[1];
            dec += (1 << ns);
         end else begin
            nxt[ns] = cand[0];
         end
         if (all_hi != 0) nxt[ns] -= 128;
      end
      best = 0;
      for (int s = 0; s < 4; s++) begin
         m_pm[s] = nxt[s];
         if (nxt[s] < nxt[best]) best = s;
      end
      m_cnt = (start != 0) ? 1 : ((m_cnt < 2) ? m_cnt + 1 : 2);
      exp_dec  = dec;
      exp_st   = best;
      exp_pm   = nxt[best];
      exp_norm = all_hi;
      exp_warm = (m_cnt == 2) ? 1 : 0;
   endtask

   // Every falling edge: DUT outputs must equal the model.
   always @(negedge clk) begin
      check("valid",   int'(bus.o_valid),   exp_valid);
      check("dec",     int'(bus.o_dec),     exp_dec);
      check("best_st", int'(bus.o_best_st), exp_st);
      check("best_pm", int'(bus.o_best_pm), exp_pm);
      check("norm",    int'(bus.o_norm),    exp_norm);
      check("warm",    int'(bus.o_warm),    exp_warm);
   end

   task automatic cyc(input int en, input int start, input int b0, input int b1,
                      input int b2, input int b3);
      bus.en_a    = en[0];
      bus.i_start = start[0];
      bus.i_bm    = {b3[1:0], b2[1:0], b1[1:0], b0[1:0]};
      @(posedge clk);
      model_step(en, start, b0, b1, b2, b3);
      @(negedge clk);
   endtask

   task automatic scenario_one();
      cyc(1, 1, 0, 1, 1, 2);
      check("s1_valid", int'(bus.o_valid), 1);
      check("s1_st",    int'(bus.o_best_st), 0);
      check("s1_pm",    int'(bus.o_best_pm), 0);
      check("s1_dec0",  int'(bus.o_dec[0]), 0);
      check("s1_warm",  int'(bus.o_warm), 0);
      cyc(1, 0, 0, 1, 1, 2);
      check("s2_warm", int'(bus.o_warm), 1);
      check("s2_pm",   int'(bus.o_best_pm), 0);
      check("s2_st",   int'(bus.o_best_st), 0);
      cyc(1, 0, 0, 1, 1, 2);
      check("s3_pm", int'(bus.o_best_pm), 0);
   endtask

   initial begin
      bus.en_a    = 1'b0;
      bus.i_start = 1'b0;
      bus.i_bm    = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_pm",    int'(bus.o_best_pm), 0);
      rst = 1'b1;
      @(negedge clk);

      scenario_one();

      // Equal candidates straight after a start.
      cyc(1, 1, 1, 1, 1, 1);
      check("tie_dec", int'(bus.o_dec), 0);
      check("tie_st",  int'(bus.o_best_st), 0);
      check("tie_pm",  int'(bus.o_best_pm), 1);

      // Assorted branch-metric patterns, model-checked.
      cyc(1, 0, 2, 0, 1, 3);
      cyc(1, 0, 0, 3, 2, 1);
      cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 0, 3, 2, 1, 0);
      cyc(1, 0, 0, 0, 3, 3);
      cyc(1, 0, 3, 1, 2, 0);

      // Gap mid-frame, including a start pulse without en_a.
      cyc(1, 1, 0, 1, 1, 2);
      cyc(1, 0, 2, 1, 0, 3);
      for (int i = 0; i < 5; i++) cyc(0, (i == 2) ? 1 : 0, 3, 3, 0, 0);
      check("gap_valid", int'(bus.o_valid), 0);
      cyc(1, 0, 0, 1, 1, 2);
      check("gap_resume_valid", int'(bus.o_valid), 1);
      check("gap_resume_warm",  int'(bus.o_warm), 1);

      // Constant worst metric: all states climb together until normalisation.
      cyc(1, 1, 3, 3, 3, 3);
      check("nrm_first_pm", int'(bus.o_best_pm), 3);
      for (int i = 2; i <= 50; i++) begin
         cyc(1, 0, 3, 3, 3, 3);
         if (i == 43) begin
            check("nrm_pre_pm",   int'(bus.o_best_pm), 129);
            check("nrm_pre_flag", int'(bus.o_norm), 0);
         end
         if (i == 44) begin
            check("nrm_pm",   int'(bus.o_best_pm), 4);
            check("nrm_flag", int'(bus.o_norm), 1);
         end
         if (i == 45) check("nrm_post_pm", int'(bus.o_best_pm), 7);
      end

      // Reset in the middle of a frame.
      cyc(1, 1, 2, 0, 3, 1);
      cyc(1, 0, 1, 2, 0, 3);
      bus.en_a = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("mrst_valid", int'(bus.o_valid), 0);
      check("mrst_dec",   int'(bus.o_dec), 0);
      check("mrst_st",    int'(bus.o_best_st), 0);
      check("mrst_pm",    int'(bus.o_best_pm), 0);
      check("mrst_norm",  int'(bus.o_norm), 0);
      check("mrst_warm",  int'(bus.o_warm), 0);
      bus.en_a = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      scenario_one();

      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/viterbi_acs_array.md
# viterbi_acs_array

Parametrised radix-2 add-compare-select array for the Viterbi decoder, the next generation of the fixed 4-state ACS stage. Per accepted symbol it adds externally supplied branch metrics to the stored path metrics of all 2^(K-1) trellis states and selects survivors. It emits one decision bit per state plus the best state and metric to the traceback unit. Path metrics are kept bounded by modulo normalisation, and a warm-up flag marks when the trellis is fully populated.

## Interface
- K, 3: constraint length; NS = 2^(K-1) states.
- G0, 3'b111: generator polynomial for code bit c0, K bits, MSB = oldest bit.
- G1, 3'b101: generator polynomial for code bit c1.
- BM_W, 2: branch-metric width; BM_MAX = 2^BM_W-1.
- PM_W, 8: path-metric width; elaboration fails unless 2^(PM_W-2) > 2*(K-1)*BM_MAX+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en_a  in  1  symbol valid; one trellis step per cycle while high.
- i_start  in  1  qualified by en_a; re-initialise metrics before this symbol (frame start).
- i_bm  in  4*BM_W  branch metrics; slice n = metric of codeword n = {c0,c1}.
- o_dec  out  NS  survivor decisions; bit s = 1 when state s chose predecessor p1.
- o_valid  out  1  o_dec/o_best_* valid this cycle.
- o_best_st  out  K-1  index of minimum new path metric.
- o_best_pm  out  PM_W  that minimum metric.
- o_norm  out  1  normalisation applied on this step.
- o_warm  out  1  at least K-1 steps taken since last start.

## Operation
- Trellis: next state ns = {s[K-3:0], u}; predecessors p0 = {0, ns[K-2:1]}, p1 = {1, ns[K-2:1]}; input u = ns[0].
- Codeword for transition p->ns: r = {p, u}; c0 = ^(r & G0), c1 = ^(r & G1); index n = {c0,c1}.
- Candidates: cj = pm[pj] + i_bm[n(pj,ns)] (PM_W bits, no overflow by width rule). New pm[ns] = min(c0,c1); tie selects p0 (o_dec bit 0).
- Start: when en_a & i_start, source metrics for this step are pm[0]=0, pm[others]=BIAS=2^(PM_W-2), not the stored values.
- Normalisation: if every source metric has bit PM_W-1 set, subtract 2^(PM_W-1) from all new metrics and assert o_norm; relative differences unchanged.
- Best state: lowest index wins on equal metrics.
- Step counter saturates at K-1; cleared by start (start step counts as step 1); o_warm = counter==K-1 after the step.
- en_a low: metrics, counter held; o_valid 0; o_dec/o_best_* hold last values.

## Timing
- Latency 1: symbol accepted on edge t; outputs and updated metrics valid after edge t, o_valid high for exactly that cycle.
- Full throughput, no backpressure; back-to-back en_a every cycle supported.
- Reset (any time, mid-frame included): pm[0]=0, others BIAS; counter 0; o_valid, o_dec, o_best_st, o_best_pm, o_norm, o_warm all 0. No partial step survives reset.
- i_start without en_a is ignored.

## Structure
- Package viterbi_pkg: default K/G0/G1/BM_W/PM_W, NS derivation, BIAS constant, parity/codeword function, predecessor function.
- Sub-module acs_cell: one next state — two adders, compare, select, decision bit; instantiated NS times via generate.
- Top holds metric registers, normalisation detect, min-tree for best state, step counter.

## Test plan
- Defaults, after reset, en_a+i_start, i_bm = {00:0, 01:1, 10:1, 11:2} -> next cycle o_valid=1, o_best_st=0, o_best_pm=0, o_dec[0]=0, o_warm=0.
- Continue same all-zero stream second step -> o_warm=1, o_best_pm=0, o_best_st=0; third step still 0.
- Equal candidates forced (i_bm all 1 right after start from equal metrics) -> every tied o_dec bit = 0, o_best_st = lowest tied index.
- All i_bm = 3 for ~43 steps -> first step with all metrics ≥128 gives o_norm=1 and o_best_pm drops by 128; metric differences identical before/after.
- en_a low 5 cycles mid-frame -> o_valid 0, outputs held; resume gives same result as without gap.
- rst pulsed mid-frame -> all outputs 0 immediately; next start frame reproduces scenario 1 exactly.
